// File: rtl/zx81_reset_seq_if.sv
// zx81_reset_seq_if: bundles the sequencer's request inputs and reset/status outputs.
// master drives the request side (board top / bench), slave is the sequencer.
interface zx81_reset_seq_if #(
    parameter int unsigned N_OUT = 3
);
    logic             pll_locked;
    logic             btn;
    logic             soft_req;
    logic             wdt_kick;
    logic [N_OUT-1:0] rst_n;
    logic             ready;
    logic [2:0]       cause;

    modport master (
        output pll_locked, btn, soft_req, wdt_kick,
        input  rst_n, ready, cause
    );

    modport slave (
        input  pll_locked, btn, soft_req, wdt_kick,
        output rst_n, ready, cause
    );
endinterface

// File: rtl/zx81_reset_seq.sv
// zx81_reset_seq: parametrised reset sequencer for the ZX81 board tops.
// Waits for a stable PLL lock, stretches reset, then releases N_OUT domains
// one after another (bit 0 first). Restarts on lock loss, a debounced button
// or a core soft-reset request and records the cause of the last reset.
// Optional watchdog restart is compiled in with `define ZX81_RESET_WDT_EN.
module zx81_reset_seq #(
    parameter int unsigned N_OUT       = 3,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned STRETCH     = 32,
    parameter int unsigned STAGGER     = 8,
    parameter int unsigned DEBOUNCE    = 1024,
    parameter int unsigned WDT_CYCLES  = 2**20
) (
    input  logic             clk_sys,
    input  logic             reset,
    zx81_reset_seq_if.slave  bus
);

    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned STR_W  = $clog2(STRETCH + 1);
    localparam int unsigned STG_W  = $clog2(STAGGER + 1);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);

    localparam logic [2:0] CAUSE_PLL  = 3'd1;
    localparam logic [2:0] CAUSE_BTN  = 3'd2;
    localparam logic [2:0] CAUSE_SOFT = 3'd3;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [LOCK_W-1:0]  lock_cnt, lock_cnt_nxt;
    logic [STR_W-1:0]   str_cnt, str_cnt_nxt;
    logic [STG_W-1:0]   stg_cnt, stg_cnt_nxt;
    logic [N_OUT-1:0]   rst_n_q, rst_n_nxt;
    logic               ready_q, ready_nxt;
    logic [2:0]         cause_q, cause_nxt;

    logic               lock_s1, lock_s;
    logic               btn_s1, btn_s;
    logic [DB_W-1:0]    db_cnt;
    logic               btn_db;
    logic               btn_ev_c;
    logic               wdt_ev_c;

    // Two-flop synchronisers for the asynchronous lock and button inputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
            btn_s1  <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            lock_s1 <= bus.pll_locked;
            lock_s  <= lock_s1;
            btn_s1  <= bus.btn;
            btn_s   <= btn_s1;
        end
    end

    // Rising edge of the debounced level, seen in the cycle the level is accepted.
    assign btn_ev_c = btn_s && !btn_db && (db_cnt == DB_W'(DEBOUNCE - 1));

    // Debounce: any return to the accepted level restarts the stability count.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
            db_cnt <= '0;
            btn_db <= btn_s;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

`ifdef ZX81_RESET_WDT_EN
    localparam int unsigned WDT_W      = $clog2(WDT_CYCLES + 1);
    localparam logic [2:0]  CAUSE_WDT  = 3'd4;

    logic [WDT_W-1:0] wdt_cnt;

    assign wdt_ev_c = (state == ST_RUN) && !bus.wdt_kick &&
                      (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    // Watchdog only counts while staying in RUN; any kick or restart clears it.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wdt_cnt <= '0;
        end else if (state == ST_RUN && state_nxt == ST_RUN && !bus.wdt_kick) begin
            if (wdt_cnt != WDT_W'(WDT_CYCLES - 1)) begin
                wdt_cnt <= wdt_cnt + WDT_W'(1);
            end
        end else begin
            wdt_cnt <= '0;
        end
    end
`else
    logic unused_wdt;

    assign wdt_ev_c   = 1'b0;
    assign unused_wdt = &{1'b0, bus.wdt_kick, WDT_CYCLES[0]};
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= ST_HOLD;
            lock_cnt <= '0;
            str_cnt  <= '0;
            stg_cnt  <= '0;
            rst_n_q  <= '0;
            ready_q  <= 1'b0;
            cause_q  <= 3'd0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            str_cnt  <= str_cnt_nxt;
            stg_cnt  <= stg_cnt_nxt;
            rst_n_q  <= rst_n_nxt;
            ready_q  <= ready_nxt;
            cause_q  <= cause_nxt;
        end
    end

    // Next-state, counter and output logic; restart events override the sequence.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        str_cnt_nxt  = str_cnt;
        stg_cnt_nxt  = stg_cnt;
        rst_n_nxt    = rst_n_q;
        ready_nxt    = ready_q;
        cause_nxt    = cause_q;

        case (state)
            ST_HOLD: begin
                rst_n_nxt = '0;
                ready_nxt = 1'b0;
                if (!lock_s) begin
                    lock_cnt_nxt = '0;
                end else if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                    lock_cnt_nxt = '0;
                    str_cnt_nxt  = '0;
                    state_nxt    = ST_STRETCH;
                end else begin
                    lock_cnt_nxt = lock_cnt + LOCK_W'(1);
                end
                if (btn_ev_c) begin
                    cause_nxt = CAUSE_BTN;
                end else if (bus.soft_req) begin
                    cause_nxt = CAUSE_SOFT;
                end
            end

            ST_STRETCH: begin
                if (str_cnt == STR_W'(STRETCH - 1)) begin
                    str_cnt_nxt = '0;
                    stg_cnt_nxt = '0;
                    rst_n_nxt   = N_OUT'(1);
                    if (&rst_n_nxt) begin
                        ready_nxt = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_RELEASE;
                    end
                end else begin
                    str_cnt_nxt = str_cnt + STR_W'(1);
                end
            end

            ST_RELEASE: begin
                // Released bits form a contiguous run from bit 0; shift in the next one.
                if (stg_cnt == STG_W'(STAGGER - 1)) begin
                    stg_cnt_nxt = '0;
                    rst_n_nxt   = (rst_n_q << 1) | N_OUT'(1);
                    if (&rst_n_nxt) begin
                        ready_nxt = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end else begin
                    stg_cnt_nxt = stg_cnt + STG_W'(1);
                end
            end

            ST_RUN: begin
                rst_n_nxt = '1;
                ready_nxt = 1'b1;
            end

            default: begin
                state_nxt = ST_HOLD;
            end
        endcase

        // Restart priority: lock loss > button > watchdog > soft request.
        if (state != ST_HOLD) begin
            if (!lock_s || btn_ev_c || wdt_ev_c || bus.soft_req) begin
                rst_n_nxt    = '0;
                ready_nxt    = 1'b0;
                lock_cnt_nxt = '0;
                str_cnt_nxt  = '0;
                stg_cnt_nxt  = '0;
            end
            if (!lock_s) begin
                state_nxt = ST_HOLD;
                cause_nxt = CAUSE_PLL;
            end else if (btn_ev_c) begin
                state_nxt = ST_HOLD;
                cause_nxt = CAUSE_BTN;
            end else if (wdt_ev_c) begin
                state_nxt = ST_STRETCH;
`ifdef ZX81_RESET_WDT_EN
                cause_nxt = CAUSE_WDT;
`endif
            end else if (bus.soft_req) begin
                state_nxt = ST_STRETCH;
                cause_nxt = CAUSE_SOFT;
            end
        end
    end

    assign bus.rst_n = rst_n_q;
    assign bus.ready = ready_q;
    assign bus.cause = cause_q;

endmodule

// File: doc/zx81_reset_seq.md
Name: zx81_reset_seq

Overview:
- Parametrised reset sequencer. Replaces the fixed 8-clock power-on shift register in the ZX81 board tops.
- Holds every reset domain until the PLL has been stably locked, stretches reset, then releases N domains in a staggered order (video/HDMI, core, PS/2).
- Re-enters the sequence on PLL lock loss, a debounced front-panel button or a core soft-reset request.
- Reports the cause of the last reset.

Parameters:
- N_OUT, 3: number of reset domains. Bit 0 is released first.
- LOCK_CYCLES, 16: consecutive synchronised pll_locked=1 cycles required before leaving HOLD (≥1).
- STRETCH, 32: cycles spent in STRETCH (≥1).
- STAGGER, 8: cycles between consecutive domain releases (≥1).
- DEBOUNCE, 1024: cycles btn must be stable before a change is accepted.
- WDT_CYCLES, 2^20: watchdog timeout. Used only with the optional feature.

Ports:
- clk_sys  in  1  system clock (pixel clock domain)
- reset  in  1  asynchronous, active-high master reset
- pll_locked  in  1  PLL lock, asynchronous to clk_sys
- btn  in  1  raw reset button, active-high, asynchronous, bouncy
- soft_req  in  1  single-cycle soft-reset request from core, synchronous to clk_sys
- wdt_kick  in  1  watchdog kick pulse. Ignored unless the feature is compiled in.
- rst_n  out  N_OUT  per-domain active-low resets
- ready  out  1  high when all domains are released
- cause  out  3  last reset cause: 0 POR, 1 PLL loss, 2 button, 3 soft, 4 watchdog

Behaviour:
- Reset is asynchronous and active-high; all flops clear on reset. While reset is high:
  - rst_n = all 0, ready = 0, cause = 0, state = HOLD.
  - All counters = 0. Synchronisers = 0. Debounced button = 0.
- pll_locked and btn each pass through a 2-flop synchroniser.
- Button debounce:
  - Counter restarts on every change of the synchronised btn.
  - The debounced level updates after DEBOUNCE stable cycles.
  - A button event is the 0→1 edge of the debounced level.
- State HOLD:
  - rst_n = 0.
  - lock_cnt increments while lock_s=1 and clears while lock_s=0.
  - When lock_cnt = LOCK_CYCLES-1 and lock_s=1, go to STRETCH and clear the counter.
- State STRETCH:
  - rst_n = 0.
  - Counts STRETCH cycles, then goes to RELEASE with idx=0.
- State RELEASE:
  - rst_n[0] deasserts on entry.
  - Every STAGGER cycles, rst_n[idx+1] deasserts.
  - Released bits stay high until the sequence restarts.
  - After bit N_OUT-1 deasserts, go to RUN. ready goes high on the same edge as rst_n[N_OUT-1].
- State RUN: holds all outputs.
- Restart events, evaluated in all states except HOLD:
  - lock_s=0 → HOLD, cause=1.
  - Button event → HOLD, cause=2.
  - soft_req → STRETCH (lock wait skipped), cause=3.
- Restart effect:
  - On the edge after the event, rst_n = all 0 and ready = 0.
  - Stagger and stretch counters clear.
  - A restart mid-RELEASE reasserts all bits, including already-released ones.
- Priority when events coincide: lock loss > button > soft. Only the highest-priority cause is recorded.
- A button event or soft_req while in HOLD: cause updates (button 2, soft 3), state stays HOLD.
- N_OUT=1: ready rises with rst_n[0] on RELEASE entry; STAGGER is unused.
- Counters are sized with $clog2(param+1) and never wrap. Each saturates at its terminal value.
- Release latency from the first edge with reset=0 and pll_locked=1 = 2 + LOCK_CYCLES + STRETCH + k·STAGGER for bit k.

Optional Feature:
- Macro: ZX81_RESET_WDT_EN.
- Compiled in:
  - A watchdog counter runs only in RUN and clears on wdt_kick.
  - Reaching WDT_CYCLES-1 without a kick → STRETCH, cause=4.
  - Priority: below button, above soft_req.
  - The counter clears on every restart.
- Compiled out:
  - wdt_kick is ignored, no watchdog logic is generated, and cause never equals 4.

Test Plan:
- Defaults. Deassert reset at cycle 0 with pll_locked=1 → rst_n[0] rises at cycle 50, rst_n[1] at 58, rst_n[2] and ready at 66, cause=0.
- pll_locked glitches low for 1 cycle at cycle 10 → lock_cnt clears. rst_n[0] rises at cycle 50 + (cycles lost) and never earlier. cause stays 0.
- In RUN, drop pll_locked → 3 cycles later rst_n=000, ready=0, cause=1. Re-raise lock → release after 2+16+32 cycles.
- Pulse soft_req at cycle 60 (mid-RELEASE, rst_n=011) → next edge rst_n=000. rst_n[0] rises 32 cycles later, cause=3.
- btn bounces 5 times within 200 cycles, then holds high, with DEBOUNCE=16 → exactly one restart, cause=2. Simultaneous soft_req on the event cycle → cause stays 2.
- Build with ZX81_RESET_WDT_EN and WDT_CYCLES=64: no kick in RUN → restart after 64 cycles, cause=4. A kick every 50 cycles → no restart.
